// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo FSM state type and tick-constant helpers
package servo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } servo_state_e;

    localparam logic [7:0] CODE_MAX  = 8'd255;
    localparam logic [1:0] FILL_DONE = 2'd3;

    function automatic logic [31:0] us_to_ticks(input int unsigned freq, input int unsigned us);
        return 32'(freq / 32'd1000000 * us);
    endfunction

    function automatic logic [31:0] step_ticks(input logic [31:0] min_t, input logic [31:0] max_t);
        return (max_t - min_t) / 32'd255;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - 2-FF synchronizer with registered rise/fall pulses
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic sync1_q, sync2_q, sync3_q;
    logic rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        rise_d = sync2_q & ~sync3_q;
        fall_d = ~sync2_q & sync3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // level is taken from the third stage so it lines up with the edge pulses
    assign level = sync3_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - measures servo PWM pulses and converts them to an 8-bit position code
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned in_freq      = 50000000,
    parameter int unsigned min_pulse_us = 500,
    parameter int unsigned max_pulse_us = 2500,
    parameter int unsigned timeout_us   = 25000
) (
    input  logic        Main_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        servo_pwm_in,
    output logic [7:0]  duty_cycle,
    output logic [31:0] pulse_ticks,
    output logic [31:0] period_ticks,
    output logic        valid,
    output logic        range_err,
    output logic        signal_lost
);
    localparam logic [31:0] MIN_T  = us_to_ticks(in_freq, min_pulse_us);
    localparam logic [31:0] MAX_T  = us_to_ticks(in_freq, max_pulse_us);
    localparam logic [31:0] TO_T   = us_to_ticks(in_freq, timeout_us);
    localparam logic [31:0] STEP_T = step_ticks(MIN_T, MAX_T);

    logic pwm_level, pwm_rise, pwm_fall;

    sync_edge_detect u_sync (
        .clk   (Main_clock),
        .rst_n (reset),
        .din   (servo_pwm_in),
        .level (pwm_level),
        .rise  (pwm_rise),
        .fall  (pwm_fall)
    );

    servo_state_e state_q, state_d;
    logic [1:0]   fill_q, fill_d;
    logic [31:0]  width_q, width_d;
    logic [31:0]  period_q, period_d;
    logic [31:0]  pulse_ticks_q, pulse_ticks_d;
    logic [31:0]  period_ticks_q, period_ticks_d;
    logic         conv_busy_q, conv_busy_d;
    logic [31:0]  conv_rem_q, conv_rem_d;
    logic [7:0]   conv_code_q, conv_code_d;
    logic         conv_err_q, conv_err_d;
    logic [7:0]   duty_q, duty_d;
    logic         valid_q, valid_d;
    logic         range_err_q, range_err_d;
    logic         lost_q, lost_d;
    logic         timeout;

    // period counter doubles as the watchdog: it runs from the last rise (or from WAIT_RISE entry)
    assign timeout = (period_q >= TO_T);

    always_comb begin
        state_d        = state_q;
        fill_d         = (fill_q == FILL_DONE) ? fill_q : fill_q + 2'd1;
        width_d        = width_q;
        period_d       = period_q;
        pulse_ticks_d  = pulse_ticks_q;
        period_ticks_d = period_ticks_q;
        conv_busy_d    = conv_busy_q;
        conv_rem_d     = conv_rem_q;
        conv_code_d    = conv_code_q;
        conv_err_d     = conv_err_q;
        duty_d         = duty_q;
        valid_d        = 1'b0;
        range_err_d    = range_err_q;
        lost_d         = lost_q;

        if (!enable) begin
            state_d     = ST_IDLE;
            width_d     = '0;
            period_d    = '0;
            conv_busy_d = 1'b0;
        end else begin
            if (conv_busy_q) begin
                if (conv_rem_q >= STEP_T && conv_code_q != CODE_MAX) begin
                    conv_rem_d  = conv_rem_q - STEP_T;
                    conv_code_d = conv_code_q + 8'd1;
                end else begin
                    conv_busy_d = 1'b0;
                    valid_d     = 1'b1;
                    duty_d      = conv_code_q;
                    range_err_d = conv_err_q;
                    lost_d      = 1'b0;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    width_d  = '0;
                    period_d = '0;
                    if (!pwm_level && fill_q == FILL_DONE) begin
                        state_d = ST_WAIT_RISE;
                    end
                end
                ST_WAIT_RISE: begin
                    if (timeout) begin
                        state_d = ST_IDLE;
                        lost_d  = 1'b1;
                    end else if (pwm_rise) begin
                        state_d  = ST_HIGH;
                        width_d  = 32'd1;
                        period_d = 32'd1;
                    end else begin
                        period_d = sat_inc(period_q);
                    end
                end
                ST_HIGH: begin
                    if (timeout) begin
                        state_d = ST_IDLE;
                        lost_d  = 1'b1;
                    end else if (pwm_fall) begin
                        state_d       = ST_LOW;
                        pulse_ticks_d = width_q;
                        period_d      = sat_inc(period_q);
                        // a new fall always restarts conversion, discarding any in flight
                        conv_busy_d   = 1'b1;
                        conv_code_d   = 8'd0;
                        if (width_q < MIN_T) begin
                            conv_rem_d = '0;
                            conv_err_d = 1'b1;
                        end else begin
                            conv_rem_d = width_q - MIN_T;
                            conv_err_d = (width_q > MAX_T);
                        end
                    end else begin
                        width_d  = sat_inc(width_q);
                        period_d = sat_inc(period_q);
                    end
                end
                ST_LOW: begin
                    if (timeout) begin
                        state_d = ST_IDLE;
                        lost_d  = 1'b1;
                    end else if (pwm_rise) begin
                        state_d        = ST_HIGH;
                        period_ticks_d = period_q;
                        period_d       = 32'd1;
                        width_d        = 32'd1;
                    end else begin
                        period_d = sat_inc(period_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Main_clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            fill_q         <= 2'd0;
            width_q        <= '0;
            period_q       <= '0;
            pulse_ticks_q  <= '0;
            period_ticks_q <= '0;
            conv_busy_q    <= 1'b0;
            conv_rem_q     <= '0;
            conv_code_q    <= 8'd0;
            conv_err_q     <= 1'b0;
            duty_q         <= 8'd0;
            valid_q        <= 1'b0;
            range_err_q    <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_q         <= fill_d;
            width_q        <= width_d;
            period_q       <= period_d;
            pulse_ticks_q  <= pulse_ticks_d;
            period_ticks_q <= period_ticks_d;
            conv_busy_q    <= conv_busy_d;
            conv_rem_q     <= conv_rem_d;
            conv_code_q    <= conv_code_d;
            conv_err_q     <= conv_err_d;
            duty_q         <= duty_d;
            valid_q        <= valid_d;
            range_err_q    <= range_err_d;
            lost_q         <= lost_d;
        end
    end

    assign duty_cycle   = duty_q;
    assign pulse_ticks  = pulse_ticks_q;
    assign period_ticks = period_ticks_q;
    assign valid        = valid_q;
    assign range_err    = range_err_q;
    assign signal_lost  = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - self-checking bench for servo_pwm_decoder
module tb_servo_pwm_decoder;

    localparam int MIN_T  = 2500;
    localparam int MAX_T  = 12500;
    localparam int STEP_T = 39;
    localparam int TO_T   = 125000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pin = 1'b0;
    logic [7:0]  duty_cycle;
    logic [31:0] pulse_ticks;
    logic [31:0] period_ticks;
    logic        valid;
    logic        range_err;
    logic        signal_lost;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rise  = 0;
    int exp_period = 0;
    bit rise_armed = 1'b0;

    typedef struct {
        int code;
        bit err;
        int width;
        int period;
        int fall_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   widths[9] = '{2500, 2538, 2537, 12500, 12499, 2000, 13000, 2499, 12501};

    servo_pwm_decoder #(.in_freq(5000000)) dut (
        .Main_clock   (clk),
        .reset        (rst_n),
        .enable       (enable),
        .servo_pwm_in (pin),
        .duty_cycle   (duty_cycle),
        .pulse_ticks  (pulse_ticks),
        .period_ticks (period_ticks),
        .valid        (valid),
        .range_err    (range_err),
        .signal_lost  (signal_lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // position code from pulse width by direct division, clamped to the code range
    function automatic void ref_code(input int n, output int code, output bit err);
        if (n < MIN_T) begin
            code = 0;
            err  = 1'b1;
        end else begin
            code = (n - MIN_T) / STEP_T;
            if (code > 255) code = 255;
            err = (n > MAX_T);
        end
    endfunction

    task automatic pulse(input int high, input int low);
        exp_t e;
        pin = 1'b1;
        if (rise_armed) exp_period = cyc - last_rise;
        last_rise  = cyc;
        rise_armed = 1'b1;
        repeat (high) @(posedge clk);
        #1;
        pin = 1'b0;
        ref_code(high, e.code, e.err);
        e.width    = high;
        e.period   = exp_period;
        e.fall_cyc = cyc;
        exp_q.push_back(e);
        repeat (low) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            check("valid_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("duty_cycle", duty_cycle, mon_e.code);
                check("range_err", range_err, 64'(mon_e.err));
                check("pulse_ticks", pulse_ticks, mon_e.width);
                check("period_ticks", period_ticks, mon_e.period);
                check("valid_latency", cyc - mon_e.fall_cyc, mon_e.code + 5);
                check("lost_cleared", signal_lost, 0);
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int guard;
        pin    = 1'b0;
        enable = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_duty", duty_cycle, 0);
        check("rst_pulse", pulse_ticks, 0);
        check("rst_period", period_ticks, 0);
        check("rst_valid", valid, 0);
        check("rst_range", range_err, 0);
        check("rst_lost", signal_lost, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // nominal centre frames
        pulse(7500, 92500);
        pulse(7500, 92500);
        pulse(7500, 500);
        check("period_nominal", period_ticks, 100000);
        check("nominal_drained", exp_q.size(), 0);

        // range boundaries
        foreach (widths[i]) pulse(widths[i], 400);

        // random frames
        repeat (12) pulse($urandom_range(1500, 14000), $urandom_range(300, 3000));

        // glitch followed closely by a real pulse
        pulse(1, 10);
        pulse(7500, 2000);

        // enable dropped during LOW
        pulse(7500, 400);
        enable = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        enable = 1'b1;
        check("en_period_held", period_ticks, exp_period);
        check("en_pulse_held", pulse_ticks, 7500);
        check("en_duty_held", duty_cycle, 128);
        rise_armed = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        pulse(7500, 2000);
        pulse(7500, 2000);

        // signal loss with input held low
        pulse(7500, 0);
        guard = 0;
        while (!signal_lost && guard < TO_T + 1000) begin
            @(negedge clk);
            guard++;
        end
        check("lost_set", signal_lost, 1);
        check("lost_delay", cyc - last_rise, TO_T + 4);
        check("lost_duty_held", duty_cycle, 128);
        @(posedge clk);
        #1;
        rise_armed = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("lost_sticky", signal_lost, 1);
        pulse(7500, 2000);
        check("lost_after_frame", signal_lost, 0);

        // asynchronous reset in the middle of a high pulse
        pin = 1'b1;
        repeat (1000) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_duty", duty_cycle, 0);
        check("arst_pulse", pulse_ticks, 0);
        check("arst_period", period_ticks, 0);
        check("arst_valid", valid, 0);
        check("arst_range", range_err, 0);
        check("arst_lost", signal_lost, 0);
        exp_period = 0;
        rise_armed = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        pin = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        pulse(7500, 2000);

        repeat (300) @(posedge clk);
        #1;
        check("pending_valids", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

Interface
REQ-001 SHALL have parameter in_freq, default 50000000, meaning Main_clock frequency in Hz.
REQ-002 SHALL have parameter min_pulse_us, default 500, meaning the pulse width for code 0 (-90 deg).
REQ-003 SHALL have parameter max_pulse_us, default 2500, meaning the pulse width for code 255 (+90 deg).
REQ-004 SHALL have parameter timeout_us, default 25000, meaning the maximum high or low time before signal loss is declared.
REQ-005 SHALL have port Main_clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1 bit; when low, the block holds state IDLE and the counters are cleared.
REQ-008 SHALL have port servo_pwm_in, input, 1 bit, the asynchronous servo PWM line.
REQ-009 SHALL have port duty_cycle, output, 8 bits, the decoded position code.
REQ-010 SHALL have port pulse_ticks, output, 32 bits, the last measured high time in clocks.
REQ-011 SHALL have port period_ticks, output, 32 bits, the last measured rising-to-rising time in clocks.
REQ-012 SHALL have port valid, output, 1 bit, a one-cycle strobe when duty_cycle updates.
REQ-013 SHALL have port range_err, output, 1 bit, set when the last pulse was outside [min,max].
REQ-014 SHALL have port signal_lost, output, 1 bit, set on timeout.

Function
REQ-015 SHALL pass servo_pwm_in through a 2-FF synchronizer, then a registered edge detector; edges are seen 3 cycles after the pin changes.
REQ-016 SHALL derive constants as integer expressions:
- MIN_T = in_freq/1000000*min_pulse_us
- MAX_T likewise from max_pulse_us
- TO_T likewise from timeout_us
- STEP_T = (MAX_T-MIN_T)/255
REQ-017 SHALL implement FSM states IDLE, WAIT_RISE, HIGH, LOW.
- IDLE -> WAIT_RISE when enable=1 and the synced input is 0.
- WAIT_RISE -> HIGH on a rising edge.
- HIGH -> LOW on a falling edge.
- LOW -> HIGH on a rising edge.
REQ-018 SHALL count width from 1 on the rising-edge cycle in HIGH; on the falling edge, pulse_ticks SHALL load the count.
REQ-019 SHALL count period from the rising edge; at each rising edge in LOW, period_ticks SHALL load the count and the count SHALL restart at 1.
- The first rising edge after WAIT_RISE SHALL NOT update period_ticks.
REQ-020 SHALL start conversion on the falling edge:
- remainder = pulse - MIN_T.
- Subtract STEP_T once per cycle, incrementing a code counter, while remainder >= STEP_T and code < 255.
REQ-021 SHALL, the cycle after conversion terminates, load duty_cycle with the code and pulse valid for exactly one cycle.
- Latency from falling-edge detection to valid is code+2 cycles, at most 257.
REQ-022 SHALL, when pulse < MIN_T, give code 0 with range_err=1; when pulse > MAX_T, give code 255 with range_err=1; otherwise range_err=0.
- range_err updates together with valid.
REQ-023 SHALL run conversion concurrently with LOW counting.
- A rising edge during conversion SHALL NOT abort it.
- A new falling edge during conversion SHALL restart conversion with the new width, and no valid is emitted for the aborted one.
REQ-024 SHALL saturate width and period counters at 32'hFFFFFFFF.
REQ-025 SHALL, when the count reaches TO_T in HIGH, LOW or WAIT_RISE, set signal_lost=1 and go to IDLE; duty_cycle holds its last value.
REQ-026 SHALL clear signal_lost on the next valid.
REQ-027 SHALL, when enable is deasserted mid-frame, go to IDLE the next cycle, with no valid and outputs held.

Reset
REQ-028 SHALL, while reset=0, asynchronously force:
- state IDLE
- synchronizer flops 0
- duty_cycle=8'd0, pulse_ticks=0, period_ticks=0
- valid=0, range_err=0, signal_lost=0
REQ-029 SHALL leave IDLE no earlier than the third cycle after reset release, once the synchronizer is refilled.

Structure
REQ-030 SHALL place the FSM state typedef and the tick-constant functions (us-to-ticks, STEP_T) in shared package servo_pkg, also used by the PWM generator.
REQ-031 SHALL instantiate one sub-module, sync_edge_detect (2-FF synchronizer, rise/fall pulses, async active-low reset); the rest is flat.

Verification
REQ-032 SHALL use in_freq=5000000 in the bench, giving MIN_T=2500, MAX_T=12500, STEP_T=39 and TO_T=125000.
REQ-033 Scenario: frames with 7500-tick high and 100000-tick period -> duty_cycle=128, pulse_ticks=7500, period_ticks=100000 from the 2nd frame, range_err=0, one valid per frame.
REQ-034 Scenario: 2500-tick pulse -> duty_cycle=0, range_err=0; 12500-tick pulse -> duty_cycle=255, range_err=0; 2000-tick pulse -> 0 with range_err=1; 13000-tick pulse -> 255 with range_err=1.
REQ-035 Scenario: input held low after a valid frame -> signal_lost=1 exactly 125000 counted ticks after the last rising edge; the next good frame -> valid with signal_lost=0.
REQ-036 Scenario: reset=0 asserted mid-HIGH -> all outputs 0 immediately (asynchronous); after release, the first partial pulse is ignored and the first valid follows a complete rising-to-falling pulse.
REQ-037 Scenario: 1-tick glitch high then a 7500-tick pulse 10 ticks later -> the glitch yields valid with code 0 and range_err=1; the following pulse yields 128.
REQ-038 Scenario: enable=0 for 50 cycles during LOW -> no valid or period update; the decoder resynchronizes on the next full frame.
